// File: rtl/pic_pkg.sv
// Shared constants for the priority interrupt controller:
// register map, CTRL bit positions, EOI layout and FSM states.
package pic_pkg;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_EOI  = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  localparam int CTRL_LTIM = 0;
  localparam int CTRL_AEOI = 1;
  localparam int CTRL_ROT  = 2;
  localparam int CTRL_BASE = 8;

  localparam int EOI_SPECIFIC = 31;

  typedef logic [1:0] pic_state_t;

  localparam pic_state_t ST_IDLE = 2'd0;
  localparam pic_state_t ST_ACK1 = 2'd1;
  localparam pic_state_t ST_VEC  = 2'd2;

endpackage

// File: rtl/pic_core_n_if.sv
// Synchronous configuration register port of the PIC core.
// master drives strobe/address/data, slave returns read data.
interface pic_core_n_if;

  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata
  );

endinterface

// File: rtl/pic_prio_resolver.sv
// Rotating find-first: scans levels from ptr upward, stops at the
// first in-service level, reports the first requesting level before it.
module pic_prio_resolver #(
  parameter int N  = 8,
  parameter int LW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  isr,
  input  logic [LW-1:0] ptr,
  output logic          found,
  output logic [LW-1:0] level
);

  int   idx;
  logic blocked;

  always_comb begin
    found   = 1'b0;
    level   = '0;
    blocked = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && !blocked) begin
        if (isr[idx]) begin
          blocked = 1'b1;
        end else if (req[idx]) begin
          found = 1'b1;
          level = LW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/pic_core_n.sv
// Priority interrupt controller core: IRR/ISR/MASK, nested resolver, INTA FSM.
// Define PIC_ROTATE_EN to implement rotating priority (CTRL.ROT).
module pic_core_n
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  pic_core_n_if.slave      bus,
  output logic             int_o,
  input  logic             inta_i,
  output logic             vec_valid,
  output logic [VEC_W-1:0] vec_o
);

  localparam int LVL_W = $clog2(N_IRQ);
  localparam logic [LVL_W-1:0] SPUR = LVL_W'(N_IRQ - 1);

  logic [N_IRQ-1:0] irr, isr, mask, irq_q;
  logic [N_IRQ-1:0] isr_set, isr_clr, irr_clr;
  logic             ltim, aeoi, rot;
  logic [7:0]       base;
  logic             inta_q, inta_edge;
  pic_state_t       state;
  logic [LVL_W-1:0] win, prio_ptr;
  logic             spur;

  logic             req_found, isr_found;
  logic [LVL_W-1:0] req_lvl, isr_lvl;

  logic             wr_mask, wr_ctrl, wr_eoi;
  logic             eoi_spec, eoi_ns;
  logic [LVL_W-1:0] eoi_lvl;
  logic             ack1, ack2, aeoi_clr;
  logic             unused_ok;

  pic_prio_resolver #(.N(N_IRQ), .LW(LVL_W)) u_req (
    .req   (irr & ~mask),
    .isr   (isr),
    .ptr   (prio_ptr),
    .found (req_found),
    .level (req_lvl)
  );

  // Highest in-service level, for non-specific EOI
  pic_prio_resolver #(.N(N_IRQ), .LW(LVL_W)) u_isr (
    .req   (isr),
    .isr   ('0),
    .ptr   (prio_ptr),
    .found (isr_found),
    .level (isr_lvl)
  );

  assign wr_mask  = bus.cfg_we && (bus.cfg_addr == ADDR_MASK);
  assign wr_ctrl  = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
  assign wr_eoi   = bus.cfg_we && (bus.cfg_addr == ADDR_EOI);
  assign eoi_spec = bus.cfg_wdata[EOI_SPECIFIC];
  assign eoi_lvl  = bus.cfg_wdata[LVL_W-1:0];
  assign eoi_ns   = wr_eoi && !eoi_spec && isr_found;

  assign inta_edge = inta_i && !inta_q;
  assign ack1      = (state == ST_IDLE) && inta_edge;
  assign ack2      = (state == ST_ACK1) && inta_edge;
  assign aeoi_clr  = (state == ST_VEC) && aeoi && !spur;

  assign unused_ok = ^bus.cfg_wdata;

  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    irr_clr = '0;
    if (ack1 && req_found) begin
      isr_set[req_lvl] = 1'b1;
      irr_clr[req_lvl] = 1'b1;
    end
    if (aeoi_clr) begin
      isr_clr[win] = 1'b1;
    end
    if (wr_eoi) begin
      if (eoi_spec) begin
        if (int'(eoi_lvl) < N_IRQ) begin
          isr_clr[eoi_lvl] = 1'b1;
        end
      end else if (isr_found) begin
        isr_clr[isr_lvl] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr       <= '0;
      isr       <= '0;
      mask      <= '1;
      irq_q     <= '0;
      ltim      <= 1'b0;
      aeoi      <= 1'b0;
      base      <= '0;
      inta_q    <= 1'b0;
      state     <= ST_IDLE;
      win       <= '0;
      spur      <= 1'b0;
      int_o     <= 1'b0;
      vec_valid <= 1'b0;
      vec_o     <= '0;
    end else begin
      irq_q  <= irq;
      inta_q <= inta_i;
      // Set term last so a new edge beats an ack clear
      if (ltim) begin
        irr <= irq;
      end else begin
        irr <= (irr & ~irr_clr) | (irq & ~irq_q);
      end
      isr <= (isr & ~isr_clr) | isr_set;
      if (wr_mask) begin
        mask <= bus.cfg_wdata[N_IRQ-1:0];
      end
      if (wr_ctrl) begin
        ltim <= bus.cfg_wdata[CTRL_LTIM];
        aeoi <= bus.cfg_wdata[CTRL_AEOI];
        base <= bus.cfg_wdata[CTRL_BASE +: 8];
      end
      int_o     <= (state == ST_IDLE) && req_found && !inta_edge;
      vec_valid <= ack2;
      if (ack2) begin
        vec_o <= VEC_W'(base) + VEC_W'(win);
      end
      case (state)
        ST_IDLE: begin
          if (inta_edge) begin
            state <= ST_ACK1;
            win   <= req_found ? req_lvl : SPUR;
            spur  <= !req_found;
          end
        end
        ST_ACK1: begin
          if (inta_edge) begin
            state <= ST_VEC;
          end
        end
        ST_VEC:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIC_ROTATE_EN
  function automatic logic [LVL_W-1:0] nxt(input logic [LVL_W-1:0] l);
    nxt = (int'(l) == N_IRQ - 1) ? '0 : l + 1'b1;
  endfunction

  // Serviced level becomes lowest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot      <= 1'b0;
      prio_ptr <= '0;
    end else begin
      if (wr_ctrl) begin
        rot <= bus.cfg_wdata[CTRL_ROT];
      end
      if (rot && eoi_ns) begin
        prio_ptr <= nxt(isr_lvl);
      end else if (rot && aeoi_clr) begin
        prio_ptr <= nxt(win);
      end
    end
  end
`else
  assign rot      = 1'b0;
  assign prio_ptr = '0;
`endif

  always_comb begin
    bus.cfg_rdata = '0;
    unique case (1'b1)
      (bus.cfg_addr == ADDR_MASK): bus.cfg_rdata = 32'(mask);
      (bus.cfg_addr == ADDR_CTRL): begin
        bus.cfg_rdata[CTRL_LTIM]      = ltim;
        bus.cfg_rdata[CTRL_AEOI]      = aeoi;
        bus.cfg_rdata[CTRL_ROT]       = rot;
        bus.cfg_rdata[CTRL_BASE +: 8] = base;
      end
      (bus.cfg_addr == ADDR_EOI):  bus.cfg_rdata = 32'(irr);
      (bus.cfg_addr == ADDR_ISR):  bus.cfg_rdata = 32'(isr);
      default: bus.cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pic_core_n.sv
// Directed bench for pic_core_n with a vector scoreboard queue.
// Build with PIC_ROTATE_EN to exercise rotating priority.
module tb_pic_core_n;
  import pic_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  logic       int_o;
  logic       inta_i;
  logic       vec_valid;
  logic [7:0] vec_o;

  int n_chk;
  int n_fail;
  logic [7:0] exp_q[$];

  pic_core_n_if bus();

  pic_core_n #(.N_IRQ(8), .VEC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq       (irq),
    .bus       (bus),
    .int_o     (int_o),
    .inta_i    (inta_i),
    .vec_valid (vec_valid),
    .vec_o     (vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every vector strobe must match the next pushed entry
  always @(negedge clk) begin
    if (rst_n && vec_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL vec_unexpected: got %0h expected none", vec_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        assert (vec_o === e) else begin
          n_fail++;
          $error("FAIL vec: got %0h expected %0h", vec_o, e);
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] a,
                    input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    check(tag, bus.cfg_rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq = irq | m;
    @(negedge clk);
    irq = irq & ~m;
  endtask

  task automatic wait_int(input string tag);
    for (int i = 0; i < 20 && int_o !== 1'b1; i++) @(negedge clk);
    check(tag, {31'd0, int_o}, 32'd1);
  endtask

  task automatic no_int(input string tag);
    repeat (4) @(negedge clk);
    check(tag, {31'd0, int_o}, 32'd0);
  endtask

  task automatic ack(input logic [7:0] v);
    exp_q.push_back(v);
    @(negedge clk);
    inta_i = 1'b1;
    @(negedge clk);
    inta_i = 1'b0;
    check("int_ack1", {31'd0, int_o}, 32'd0);
    @(negedge clk);
    inta_i = 1'b1;
    @(negedge clk);
    inta_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    irq           = '0;
    inta_i        = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = ADDR_MASK;
    bus.cfg_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_int", {31'd0, int_o}, 32'd0);
    check("rst_vv", {31'd0, vec_valid}, 32'd0);
    check("rst_vec", {24'd0, vec_o}, 32'd0);
    rd("rst_mask", ADDR_MASK, 32'hff);
    rd("rst_ctrl", ADDR_CTRL, 32'h0);
    rd("rst_irr", ADDR_EOI, 32'h0);
    rd("rst_isr", ADDR_ISR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic edge-triggered service
    wr(ADDR_MASK, 32'h0);
    wr(ADDR_CTRL, 32'h4000);
    rd("t1_ctrl", ADDR_CTRL, 32'h4000);
    pulse(8'h08);
    wait_int("t1_int");
    rd("t1_irr_pend", ADDR_EOI, 32'h08);
    ack(8'h43);
    rd("t1_isr", ADDR_ISR, 32'h08);
    rd("t1_irr", ADDR_EOI, 32'h00);
    wr(ADDR_EOI, 32'h0);
    rd("t1_eoi", ADDR_ISR, 32'h00);

    // 2: nesting against an in-service level
    pulse(8'h04);
    wait_int("t2_int2");
    ack(8'h42);
    rd("t2_isr2", ADDR_ISR, 32'h04);
    pulse(8'h20);
    no_int("t2_no5");
    pulse(8'h02);
    wait_int("t2_int1");
    ack(8'h41);
    rd("t2_isr21", ADDR_ISR, 32'h06);
    wr(ADDR_EOI, 32'h0);
    rd("t2_eoi1", ADDR_ISR, 32'h04);
    no_int("t2_still5");
    wr(ADDR_EOI, 32'h0);
    rd("t2_eoi2", ADDR_ISR, 32'h00);
    wait_int("t2_int5");
    ack(8'h45);
    wr(ADDR_EOI, 32'h0);

    // 3: automatic EOI
    wr(ADDR_CTRL, 32'h2002);
    pulse(8'h80);
    wait_int("t3_int");
    ack(8'h27);
    rd("t3_isr", ADDR_ISR, 32'h00);

    // 4: request withdrawn before acknowledge -> spurious
    wr(ADDR_CTRL, 32'h4000);
    pulse(8'h80);
    wait_int("t4_int7");
    ack(8'h47);
    pulse(8'h40);
    wait_int("t4_int6");
    wr(ADDR_MASK, 32'hff);
    ack(8'h47);
    rd("t4_isr", ADDR_ISR, 32'h80);
    wr(ADDR_EOI, 32'h8000_0007);
    rd("t4_spec", ADDR_ISR, 32'h00);
    wr(ADDR_EOI, 32'h8000_000f);
    rd("t4_irr6", ADDR_EOI, 32'h40);
    wr(ADDR_MASK, 32'h0);
    wait_int("t4_unmask");
    ack(8'h46);
    wr(ADDR_EOI, 32'h0);

    // 5: edge vs level with a held request
    @(negedge clk);
    irq = 8'h10;
    wait_int("t5_edge_int");
    ack(8'h44);
    wr(ADDR_EOI, 32'h0);
    no_int("t5_edge_none");
    irq = 8'h00;
    wr(ADDR_CTRL, 32'h4001);
    @(negedge clk);
    irq = 8'h10;
    wait_int("t5_lvl_int");
    ack(8'h44);
    rd("t5_lvl_isr", ADDR_ISR, 32'h10);
    rd("t5_lvl_irr", ADDR_EOI, 32'h10);
    wr(ADDR_EOI, 32'h0);
    wait_int("t5_lvl_again");
    irq = 8'h00;
    no_int("t5_lvl_drop");
    wr(ADDR_CTRL, 32'h4000);

    // 6: rotation, or fixed order without it
`ifdef PIC_ROTATE_EN
    wr(ADDR_CTRL, 32'h4004);
    rd("t6_ctrl", ADDR_CTRL, 32'h4004);
    pulse(8'h01);
    wait_int("t6_int0");
    ack(8'h40);
    wr(ADDR_EOI, 32'h0);
    pulse(8'h03);
    wait_int("t6_int01");
    ack(8'h41);
    wr(ADDR_EOI, 32'h0);
    wait_int("t6_int0b");
    ack(8'h40);
    wr(ADDR_EOI, 32'h0);
    wr(ADDR_CTRL, 32'h4000);
`else
    wr(ADDR_CTRL, 32'h4004);
    rd("t6_ctrl", ADDR_CTRL, 32'h4000);
    pulse(8'h03);
    wait_int("t6_int01");
    ack(8'h40);
    wr(ADDR_EOI, 32'h0);
    wait_int("t6_int1");
    ack(8'h41);
    wr(ADDR_EOI, 32'h0);
`endif
    rd("t6_isr", ADDR_ISR, 32'h00);

    // Reset while in ACK1
    pulse(8'h08);
    wait_int("rs_int");
    @(negedge clk);
    inta_i = 1'b1;
    @(negedge clk);
    inta_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rs_int_low", {31'd0, int_o}, 32'd0);
    check("rs_vv_low", {31'd0, vec_valid}, 32'd0);
    @(negedge clk);
    inta_i = 1'b1;
    @(negedge clk);
    inta_i = 1'b0;
    check("rs_vv_hold", {31'd0, vec_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rs_vv_after", {31'd0, vec_valid}, 32'd0);
    rd("rs_isr", ADDR_ISR, 32'h00);
    rd("rs_mask", ADDR_MASK, 32'hff);
    wr(ADDR_MASK, 32'h0);
    pulse(8'h08);
    wait_int("rs_new_int");
    ack(8'h03);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
